// File: rtl/uart_tx_fifo_drain.sv
// UART 8N1 transmitter that drains a show-ahead FIFO one byte per frame.
// Start bit, 8 data bits LSB first, stop bit; frames run back-to-back while data remains.
module uart_tx_fifo_drain #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEmpty,
    input  logic [7:0] iData,
    output logic       oPop,
    output logic       oTx,
    output logic       oBusy,
    output logic       oDone
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            pop_q, pop_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntMax);

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            pop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!iEmpty) begin
                    shreg_d = iData;
                    pop_d   = 1'b1;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    tx_d    = shreg_q[0];
                    idx_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        // next bit is bit 1 of the pre-shift register
                        tx_d  = shreg_q[1];
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    if (!iEmpty) begin
                        shreg_d = iData;
                        pop_d   = 1'b1;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign oPop  = pop_q;
    assign oTx   = tx_q;
    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: queue-based FIFO model, scoreboard of expected bytes,
// and a line monitor that checks every frame cycle against the 8N1 waveform.
module tb_uart_tx_fifo_drain;

    localparam int Cpb      = 4;
    localparam int FrameLen = 10 * Cpb;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iEmpty;
    logic [7:0] iData;
    logic       oPop;
    logic       oTx;
    logic       oBusy;
    logic       oDone;

    always #5 iClk = ~iClk;

    uart_tx_fifo_drain #(
        .CLKS_PER_BIT(Cpb)
    ) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEmpty(iEmpty),
        .iData (iData),
        .oPop  (oPop),
        .oTx   (oTx),
        .oBusy (oBusy),
        .oDone (oDone)
    );

    logic [7:0] fifo[$];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         in_frame = 1'b0;
    int         k = 0;
    int         n_done = 0;
    int         n_pop = 0;
    logic [7:0] cur = '0;
    logic [7:0] rx = '0;
    logic [9:0] frame = '0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0 || in_frame) && n < budget) begin
            @(negedge iClk);
            n++;
        end
        chk(n < budget, "drain_timeout", n, budget);
    endtask

    task automatic wait_k(input int target, input int budget);
        int n = 0;
        while (!(in_frame && k == target) && n < budget) begin
            @(negedge iClk);
            n++;
        end
        chk(n < budget, "wait_k_timeout", n, budget);
    endtask

    // Monitor + FIFO model: samples 1 time unit after each rising edge.
    initial begin : monitor
        bit exp_pop;
        forever begin
            @(posedge iClk);
            #1;
            cyc++;
            if (!iRst) begin
                chk(oTx === 1'b1 && oPop === 1'b0 && oBusy === 1'b0 && oDone === 1'b0,
                    "reset_idle", {oTx, oPop, oBusy, oDone}, 4'b1000);
                in_frame = 1'b0;
            end else begin
                if (in_frame) k++;
                exp_pop = (!in_frame || k == FrameLen) && !iEmpty;
                chk(oPop === exp_pop, "pop", oPop, exp_pop);
                if (in_frame && k == FrameLen) begin
                    chk(oDone === 1'b1, "done", oDone, 1);
                    n_done++;
                    in_frame = 1'b0;
                end else begin
                    chk(oDone === 1'b0, "no_done", oDone, 0);
                end
                if (oPop === 1'b1) begin
                    n_pop++;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "pop_no_data", 1, 0);
                    end else begin
                        cur      = exp_q.pop_front();
                        frame    = {1'b1, cur, 1'b0};
                        in_frame = 1'b1;
                        k        = 0;
                    end
                end
                if (in_frame) begin
                    chk(oTx === frame[k/Cpb], "tx_bit", oTx, frame[k/Cpb]);
                    chk(oBusy === 1'b1, "busy", oBusy, 1);
                    if (k >= Cpb && k < 9 * Cpb && k % Cpb == Cpb / 2) rx[(k-Cpb)/Cpb] = oTx;
                    if (k == FrameLen - 1) chk(rx === cur, "rx_byte", rx, cur);
                end else begin
                    chk(oTx === 1'b1 && oBusy === 1'b0, "idle_line", {oTx, oBusy}, 2'b10);
                end
            end
            // The FIFO consumes its head on the edge that samples the read strobe
            if (oPop === 1'b1 && fifo.size() > 0) void'(fifo.pop_front());
            iEmpty = (fifo.size() == 0);
            iData  = iEmpty ? 8'($urandom) : fifo[0];
        end
    end

    initial begin : stimulus
        logic [7:0] msg[8];
        int         p0;
        int         d0;
        msg = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36};
        iRst   = 1'b0;
        iEmpty = 1'b1;
        iData  = 8'h00;

        // Reset held with a non-empty FIFO; the byte goes out after release
        push(8'h55);
        repeat (5) @(negedge iClk);
        chk(n_pop == 0, "reset_no_pop", n_pop, 0);
        iRst = 1'b1;
        drain(200);

        // Single ':' byte
        p0 = n_pop; d0 = n_done;
        push(8'h3A);
        drain(200);
        chk(n_pop - p0 == 1, "single_pops", n_pop - p0, 1);
        chk(n_done - d0 == 1, "single_dones", n_done - d0, 1);

        // Empty FIFO with toggling data: line stays idle
        p0 = n_pop;
        repeat (100) @(negedge iClk);
        chk(n_pop == p0, "empty_no_pop", n_pop - p0, 0);

        // Preloaded "12:34:56" goes out back-to-back
        p0 = n_pop; d0 = n_done;
        for (int i = 0; i < 8; i++) push(msg[i]);
        drain(600);
        chk(n_pop - p0 == 8, "burst_pops", n_pop - p0, 8);
        chk(n_done - d0 == 8, "burst_dones", n_done - d0, 8);

        // Reset during data bit 3 aborts the frame; the next byte starts fresh
        p0 = n_pop; d0 = n_done;
        push(8'hA5);
        push(8'h5A);
        wait_k(Cpb * 4 + 1, 200);
        iRst = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        drain(300);
        chk(n_pop - p0 == 2, "abort_pops", n_pop - p0, 2);
        chk(n_done - d0 == 1, "abort_dones", n_done - d0, 1);

        // Second byte arrives mid-frame
        p0 = n_pop; d0 = n_done;
        push(8'hC3);
        wait_k(12, 200);
        push(8'h96);
        drain(300);
        chk(n_pop - p0 == 2, "midframe_pops", n_pop - p0, 2);
        chk(n_done - d0 == 2, "midframe_dones", n_done - d0, 2);

        // Random bytes with random gaps
        p0 = n_pop;
        for (int i = 0; i < 30; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 50)) @(negedge iClk);
        end
        drain(3000);
        chk(n_pop - p0 == 30, "random_pops", n_pop - p0, 30);

        repeat (3) @(negedge iClk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
